// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the SAP-style memory/PC that share its widths.
package prog_loader_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;
endpackage

// File: rtl/prog_loader_csum.sv
// Running modulo-2**DATA_W accumulator; sum_zero reports whether acc plus the current byte wraps to zero.
module prog_loader_csum #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] din,
  output logic              sum_zero
);
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] total;

  assign total    = acc + din;
  assign sum_zero = (total == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     acc <= '0;
    else if (clr) acc <= '0;
    else if (add) acc <= total;
  end
endmodule

// File: rtl/prog_loader.sv
// Streams bytes into program RAM from address 0 while holding the CPU in reset.
// Optional trailing checksum byte and ERR state enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] cnt;
  logic            start_acc;
  logic            xfer;
  logic            wr_en;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic data_phase;
  logic csum_ok;

  // Once cnt reaches len_q the next accepted byte is the checksum, never written to RAM.
  assign data_phase = (cnt != len_q);

  prog_loader_csum #(.DATA_W(DATA_W)) u_csum (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_acc),
    .add      (xfer),
    .din      (in_data),
    .sum_zero (csum_ok)
  );
`else
  logic last_data;
  assign last_data = ((cnt + ONE) == len_q);
`endif

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    xfer      = 1'b0;
    wr_en     = 1'b0;
    case (state)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) begin
          state_nxt = S_LOAD;
          start_acc = 1'b1;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          xfer = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          wr_en = data_phase;
          if (!data_phase) state_nxt = csum_ok ? S_FLUSH : S_ERR;
`else
          wr_en = 1'b1;
          if (last_data) state_nxt = S_FLUSH;
`endif
        end
      end
      S_FLUSH: state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign in_ready = (state == S_LOAD);
  assign busy     = (state == S_LOAD) || (state == S_FLUSH);
  assign done     = (state == S_RUN);
  assign cpu_rst  = (state != S_RUN);
`ifdef PROG_LOADER_CHECKSUM_EN
  assign err      = (state == S_ERR);
`else
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      len_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        len_q <= (len == '0) ? FULL : len;
        cnt   <= '0;
      end else if (wr_en) begin
        cnt   <= cnt + ONE;
      end
    end
  end

  // Write port stage: registered one cycle after the accepted transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= wr_en;
      if (wr_en) begin
        mem_addr  <= cnt[ADDR_W-1:0];
        mem_wdata <= in_data;
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader; checksum scenarios run when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] len = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, mem_we, cpu_rst, busy, done, err;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  prog_loader dut (
    .clk(clk), .rst(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: pops one expected {addr,data} per observed strobe.
  initial begin
    logic       prev_we = 1'b0;
    logic [3:0] prev_addr = '0;
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && mem_we) begin
        checks++;
        if (prev_we && prev_addr == mem_addr) begin
          failures++;
          $display("FAIL repeat_write: addr %0h written on two consecutive cycles", mem_addr);
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({mem_addr, mem_wdata} !== e) begin
            failures++;
            $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                     mem_addr, mem_wdata, e[11:8], e[7:0]);
          end
        end
      end
      prev_we   = rst_n && mem_we;
      prev_addr = mem_addr;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [4:0] l);
    start = 1'b1; len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit wr, input logic [3:0] a);
    int n = 0;
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL handshake_timeout: in_ready stayed 0 expected 1");
    end
    if (wr) exp_q.push_back({a, d});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_run(input string tag);
    check({tag, "_cpu_rst"}, cpu_rst, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation time limit reached expected completion");
    $fatal(1);
  end

  initial begin
    // Reset values
    #2;
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: len=3 back-to-back
    do_start(5'd3);
    check("t1_in_ready", in_ready, 1);
    check("t1_busy", busy, 1);
    check("t1_cpu_rst_load", cpu_rst, 1);
    send(8'h1A, 1, 4'd0);
    send(8'h2B, 1, 4'd1);
    send(8'h3C, 1, 4'd2);
    check("t1_flush_in_ready", in_ready, 0);
    check("t1_flush_busy", busy, 1);
    check("t1_flush_cpu_rst", cpu_rst, 1);
    check("t1_flush_mem_we", mem_we, 1);
    tick();
    check_run("t1");

    // 2: len=0 means 16 bytes, then a 17th byte is refused
    do_start(5'd0);
    for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), 1, 4'(i));
    check("t2_flush_busy", busy, 1);
    tick();
    check_run("t2");
    in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    check("t2_extra_in_ready", in_ready, 0);
    tick(); tick();
    in_valid = 1'b0;

    // 3: stalls in in_valid, start ignored mid-load
    do_start(5'd2);
    send(8'h77, 1, 4'd0);
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; len = 5'd1;
      check("t3_stall_busy", busy, 1);
      check("t3_stall_cpu_rst", cpu_rst, 1);
      tick();
    end
    start = 1'b0;
    check("t3_still_loading", in_ready, 1);
    send(8'h88, 1, 4'd1);
    tick();
    check_run("t3");

    // 4: async reset mid-load
    do_start(5'd4);
    send(8'hA1, 1, 4'd0);
    send(8'hA2, 1, 4'd1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t4_cpu_rst", cpu_rst, 1);
    check("t4_in_ready", in_ready, 0);
    check("t4_mem_we", mem_we, 0);
    check("t4_mem_addr", mem_addr, 0);
    check("t4_mem_wdata", mem_wdata, 0);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start(5'd1);
    send(8'h55, 1, 4'd0);
    tick();
    check_run("t4");

    // 5: restart from RUN
    do_start(5'd1);
    check("t5_cpu_rst_reassert", cpu_rst, 1);
    check("t5_done_low", done, 0);
    send(8'hE0, 1, 4'd0);
    tick();
    check_run("t5");

`ifdef PROG_LOADER_CHECKSUM_EN
    // 6: checksum pass and fail
    do_start(5'd2);
    send(8'h10, 1, 4'd0);
    send(8'h20, 1, 4'd1);
    check("t6_csum_ready", in_ready, 1);
    send(8'hD0, 0, 4'd0);
    check("t6_flush_busy", busy, 1);
    tick();
    check_run("t6_pass");
    check("t6_pass_err", err, 0);
    do_start(5'd2);
    send(8'h10, 1, 4'd0);
    send(8'h20, 1, 4'd1);
    send(8'hD1, 0, 4'd0);
    check("t6_err", err, 1);
    check("t6_err_cpu_rst", cpu_rst, 1);
    check("t6_err_busy", busy, 0);
    check("t6_err_done", done, 0);
    tick();
    check("t6_err_sticky", err, 1);
    do_start(5'd1);
    check("t6_err_cleared", err, 0);
    check("t6_restart_busy", busy, 1);
    send(8'h05, 1, 4'd0);
    send(8'hFB, 0, 4'd0);
    tick();
    check_run("t6_recover");
`endif

    tick(); tick(); tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
